// File: rtl/mem_arbiter_if.sv
// Request/grant/return bundle joining the fetch port, the load/store port and
// the shared memory to mem_arbiter. The arbiter uses the slave view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [MASK_W-1:0] d_wmask;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// load/store: data-first priority, fetch anti-starvation, in-order return routing.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int          MASK_W     = DATA_W / 8;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]     starve_cnt;
    logic [LAT-1:0] trk_valid;
    logic [LAT-1:0] trk_owner;   // 1 = load/store port, 0 = fetch port

    logic fetch_first;
    logic grant_if;
    logic grant_d;
    logic push_read;

    logic              mem_en_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [MASK_W-1:0] mem_wmask_c;

    // NOTE: grants are qualified by rst_n so nothing is accepted or driven to
    // memory while reset is held, even though the requests may be high.
    always_comb begin
        fetch_first = (starve_cnt == STARVE_LIM);
        grant_d     = rst_n && bus.d_req && !(bus.if_req && fetch_first);
        grant_if    = rst_n && bus.if_req && (!bus.d_req || fetch_first);
        push_read   = grant_if || (grant_d && !bus.d_we);
    end

    always_comb begin
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        mem_wmask_c = '0;
        if (grant_d) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.d_we;
            mem_addr_c  = bus.d_addr;
            mem_wdata_c = bus.d_wdata;
            mem_wmask_c = bus.d_we ? bus.d_wmask : '0;
        end else if (grant_if) begin
            mem_en_c    = 1'b1;
            mem_addr_c  = bus.if_addr;
        end
    end

    // NOTE: all state uses non-blocking assignments so the shift stages read
    // their neighbours' pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            trk_valid  <= '0;
            trk_owner  <= '0;
        end else begin
            if (bus.if_req && !grant_if) begin
                if (starve_cnt != STARVE_LIM)
                    starve_cnt <= starve_cnt + 4'd1;
            end else begin
                starve_cnt <= '0;
            end

            trk_valid[0] <= push_read;
            trk_owner[0] <= grant_d;
            for (int i = 1; i < LAT; i++) begin
                trk_valid[i] <= trk_valid[i-1];
                trk_owner[i] <= trk_owner[i-1];
            end
        end
    end

    assign bus.if_gnt    = grant_if;
    assign bus.d_gnt     = grant_d;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.mem_wmask = mem_wmask_c;

    // Read data is broadcast to both ports; only rvalid marks the owner.
    assign bus.if_rvalid = trk_valid[LAT-1] && !trk_owner[LAT-1];
    assign bus.d_rvalid  = trk_valid[LAT-1] &&  trk_owner[LAT-1];
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous memory (iCE40 block RAM, fixed read latency) between the processor's instruction-fetch port and its load/store data port. Performs at most one memory access per cycle, arbitrates with data-first priority plus a fetch anti-starvation guard, and routes each read's return data back to the requester that issued it. Sits between the core and the unified memory inside `top`.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of both requesters and memory
- DATA_W, 32, data width; byte-lane count is DATA_W/8
- LAT, 1, memory read latency in cycles (legal 1..4)
- STARVE_MAX, 3, consecutive denied fetch cycles before fetch takes priority (legal 1..15)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until granted
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid this cycle
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held with fields until granted
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_wmask  in  DATA_W/8  byte-write enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid this cycle
- d_rdata  out  DATA_W  data read data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write access
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  DATA_W/8  byte enables; 0 on reads
- mem_rdata  in  DATA_W  read data, valid LAT cycles after the read's grant cycle

## Operation
- Grant is combinational from current requests and registered state; a request is accepted in a cycle where req and gnt are both high at the rising edge. At most one of if_gnt/d_gnt is high per cycle.
- Priority: d_req wins when both requests are high, unless the starve counter equals STARVE_MAX, in which case if_req wins.
- Starve counter (4 bits): increments on each edge where if_req=1 and if_gnt=0, saturating at STARVE_MAX; clears on any edge where if_gnt=1 or if_req=0.
- Memory drive: in a grant cycle, mem_* mirror the granted requester; mem_en=1. For a fetch grant, mem_we=0, mem_wmask=0, mem_wdata=0. When nothing is granted, mem_en=0, mem_we=0, and addr/wdata/wmask=0.
- Return tracking: a LAT-deep shift register of {valid, owner} entries. Each read grant pushes {1, owner}, writes and idle cycles push {0, x}, and the register advances every cycle.
- Return routing: when the output entry is valid, raise the owner's rvalid. Both rdata outputs are driven from mem_rdata continuously. Only rvalid qualifies the data.
- Writes produce no rvalid. Back-to-back pipelined reads are allowed, one per cycle; returns arrive in issue order.
- No backpressure on returns: requesters must accept rvalid whenever it fires.

## Timing
- Read granted in cycle c: the owner's rvalid is high in cycle c+LAT, for exactly one cycle.
- Write granted in cycle c: memory captures at the end of cycle c.
- Reset (rst_n=0, asynchronous): the tracking register and starve counter clear immediately. if_gnt, d_gnt, mem_en, mem_we, if_rvalid and d_rvalid are 0, and mem_addr, mem_wdata and mem_wmask are 0 while rst_n=0.
- Reset mid-operation: reads in flight at assertion never produce rvalid after release.
- First grant is possible in the first cycle after rst_n rises.
- Simultaneous requests: the grant is decided per the priority rule in that same cycle. The loser keeps its request high and is re-arbitrated next cycle.
- The starve rule guarantees a fetch waits at most STARVE_MAX cycles under continuous d_req.

## Test plan
- Reset: hold rst_n=0 with both reqs high -> all gnt/rvalid/mem_en are 0. Release -> the grant goes to data in that first cycle.
- Single fetch read, LAT=1: if_req with if_addr=0x0000_0010, memory word 0x0000_0013 at that address -> if_gnt high in cycle c, if_rvalid high with if_rdata=0x0000_0013 in cycle c+1, d_rvalid stays 0.
- Data write then read: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wmask=4'b0011 over old word 0x11223344 -> mem_wmask=0011. A subsequent read of 0x100 returns 0x1122BEEF with d_rvalid one cycle after its grant.
- Contention: if_req and d_req held high continuously with STARVE_MAX=3 -> grant pattern D,D,D,I repeating; the fetch is granted in the 4th cycle.
- Pipelined mixed reads, LAT=2: grants I@A, D@B, I@C in consecutive cycles -> if_rvalid, d_rvalid, if_rvalid in cycles c+2, c+3, c+4 with the matching data.
- Reset mid-flight: grant a read, assert rst_n low in the next cycle, then release -> no rvalid ever fires for that read.
